// File: rtl/capture_pkg.sv
// Shared types for the capture sequencer: FSM state encoding and timeout width.
package capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_ARM  = 3'd2,
    S_WAIT = 3'd3,
    S_POST = 3'd4,
    S_DONE = 3'd5
  } capture_state_t;

  localparam int TIMEOUT_WIDTH = 32;

endpackage

// File: rtl/capture_addr_gen.sv
// Circular sample-RAM write-address counter; clear wins over increment,
// natural binary wrap from 2**ADDR_WIDTH-1 back to 0.
module capture_addr_gen #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clr) begin
      addr_d = '0;
    end else if (inc) begin
      addr_d = addr_q + ADDR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/capture_sequencer.sv
// Logic-analyzer acquisition sequencer: pre-fill, arm, wait for trigger, post-fill.
// Optional trigger timeout enabled by defining CAPTURE_TIMEOUT_EN.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     valid,
  input  logic [SAMPLE_WIDTH-1:0]  cfg_rising,
  input  logic [SAMPLE_WIDTH-1:0]  cfg_falling,
  input  logic [ADDR_WIDTH-1:0]    cfg_pre,
  input  logic [ADDR_WIDTH-1:0]    cfg_post,
  input  logic                     trig_run,
`ifdef CAPTURE_TIMEOUT_EN
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  output logic                     timed_out,
`endif
  output logic                     trig_arm,
  output logic [SAMPLE_WIDTH-1:0]  trig_rising,
  output logic [SAMPLE_WIDTH-1:0]  trig_falling,
  output logic                     wr_en,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [ADDR_WIDTH-1:0]    trig_addr,
  output logic [ADDR_WIDTH-1:0]    start_addr,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  capture_state_t state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [ADDR_WIDTH-1:0]   pre_q, pre_d, post_q, post_d;
  logic [ADDR_WIDTH-1:0]   trig_addr_q, trig_addr_d, start_addr_q, start_addr_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d, cnt_inc;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    trig_arm_q, active, write, addr_clr, fire;

  assign active  = (state_q == S_PRE) || (state_q == S_ARM) ||
                   (state_q == S_WAIT) || (state_q == S_POST);
  assign write   = valid & active & ~abort;
  assign cnt_inc = cnt_q + CNT_ONE;

`ifdef CAPTURE_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic [TIMEOUT_WIDTH:0]   to_sum;
  logic                     to_hit, timed_out_q, timed_out_d;

  // The current valid cycle counts toward the timeout, so a limit of N fires on the Nth.
  assign to_sum = {1'b0, to_cnt_q} + {{TIMEOUT_WIDTH{1'b0}}, valid};
  assign to_hit = (state_q == S_WAIT) && (cfg_timeout != '0) &&
                  (to_sum == {1'b0, cfg_timeout});
  assign fire   = trig_run | to_hit;
`else
  assign fire   = trig_run;
`endif

  always_comb begin
    state_d      = state_q;
    rise_d       = rise_q;
    fall_d       = fall_q;
    pre_d        = pre_q;
    post_d       = post_q;
    cnt_d        = cnt_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    addr_clr     = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    timed_out_d  = timed_out_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            rise_d   = cfg_rising;
            fall_d   = cfg_falling;
            pre_d    = cfg_pre;
            post_d   = cfg_post;
            cnt_d    = '0;
            addr_clr = 1'b1;
            state_d  = (cfg_pre == '0) ? S_ARM : S_PRE;
`ifdef CAPTURE_TIMEOUT_EN
            to_cnt_d    = '0;
            timed_out_d = 1'b0;
`endif
          end
        end
        S_PRE: begin
          if (valid) begin
            cnt_d = cnt_inc;
            if (cnt_inc == {1'b0, pre_q}) state_d = S_ARM;
          end
        end
        S_ARM: state_d = S_WAIT;
        S_WAIT: begin
`ifdef CAPTURE_TIMEOUT_EN
          to_cnt_d = to_sum[TIMEOUT_WIDTH-1:0];
          if (to_hit && !trig_run) timed_out_d = 1'b1;
`endif
          if (fire) begin
            trig_addr_d  = addr;
            start_addr_d = addr - pre_q;
            cnt_d        = '0;
            state_d      = (post_q == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (valid) begin
            cnt_d = cnt_inc;
            if (cnt_inc == {1'b0, post_q}) state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rise_q       <= '0;
      fall_q       <= '0;
      pre_q        <= '0;
      post_q       <= '0;
      cnt_q        <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      trig_arm_q   <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
      to_cnt_q     <= '0;
      timed_out_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      pre_q        <= pre_d;
      post_q       <= post_d;
      cnt_q        <= cnt_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      trig_arm_q   <= (state_d == S_ARM);
`ifdef CAPTURE_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      timed_out_q  <= timed_out_d;
`endif
    end
  end

  capture_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clock(clock),
    .reset(reset),
    .clr  (addr_clr),
    .inc  (write),
    .addr (addr)
  );

`ifdef CAPTURE_TIMEOUT_EN
  assign timed_out = timed_out_q;
`endif
  assign trig_arm     = trig_arm_q;
  assign trig_rising  = rise_q;
  assign trig_falling = fall_q;
  assign wr_en        = write;
  assign wr_addr      = addr;
  assign trig_addr    = trig_addr_q;
  assign start_addr   = start_addr_q;
  assign busy         = active;
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized and directed bench for capture_sequencer against a sample-counting model.
module tb_capture_sequencer;

  localparam int SW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset, start, abort, valid, trig_run;
  logic [SW-1:0] cfg_rising, cfg_falling;
  logic [AW-1:0] cfg_pre, cfg_post;
  logic          trig_arm, wr_en, busy, done;
  logic [SW-1:0] trig_rising, trig_falling;
  logic [AW-1:0] wr_addr, trig_addr, start_addr;
`ifdef CAPTURE_TIMEOUT_EN
  logic [31:0]   cfg_timeout = 32'd0;
  logic          timed_out;
`endif

  always #5 clock = ~clock;

  capture_sequencer #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .valid       (valid),
    .cfg_rising  (cfg_rising),
    .cfg_falling (cfg_falling),
    .cfg_pre     (cfg_pre),
    .cfg_post    (cfg_post),
    .trig_run    (trig_run),
`ifdef CAPTURE_TIMEOUT_EN
    .cfg_timeout (cfg_timeout),
    .timed_out   (timed_out),
`endif
    .trig_arm    (trig_arm),
    .trig_rising (trig_rising),
    .trig_falling(trig_falling),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .trig_addr   (trig_addr),
    .start_addr  (start_addr),
    .busy        (busy),
    .done        (done)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: phase 0 idle, 1 pre-fill, 2 arming, 3 waiting, 4 post-fill, 5 finished.
  int m_phase, m_addr, m_pre, m_post, m_left, m_rise, m_fall, m_taddr, m_saddr;
  bit m_live = 0;
  int arm_cnt = 0;
  bit saw_wrap = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return (m_phase >= 1) && (m_phase <= 4);
  endfunction

  task automatic compare_all();
    chk("wr_en",        32'(wr_en),        32'(valid && !abort && m_busy()));
    chk("wr_addr",      32'(wr_addr),      m_addr);
    chk("trig_arm",     32'(trig_arm),     32'(m_phase == 2));
    chk("busy",         32'(busy),         32'(m_busy()));
    chk("done",         32'(done),         32'(m_phase == 5));
    chk("trig_addr",    32'(trig_addr),    m_taddr);
    chk("start_addr",   32'(start_addr),   m_saddr);
    chk("trig_rising",  32'(trig_rising),  m_rise);
    chk("trig_falling", 32'(trig_falling), m_fall);
`ifdef CAPTURE_TIMEOUT_EN
    chk("timed_out",    32'(timed_out),    32'd0);
`endif
  endtask

  task automatic model_update();
    bit wrote;
    if (reset) begin
      m_phase = 0; m_addr = 0; m_pre = 0; m_post = 0; m_left = 0;
      m_rise = 0; m_fall = 0; m_taddr = 0; m_saddr = 0; m_live = 1;
      return;
    end
    if (abort) begin
      m_phase = 0;
      return;
    end
    wrote = valid && m_busy();
    case (m_phase)
      0, 5: if (start) begin
        m_rise = int'(cfg_rising); m_fall = int'(cfg_falling);
        m_pre = int'(cfg_pre); m_post = int'(cfg_post);
        m_addr = 0; m_left = m_pre;
        m_phase = (m_pre == 0) ? 2 : 1;
      end
      1: if (valid) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
      2: m_phase = 3;
      3: if (trig_run) begin
        m_taddr = m_addr;
        m_saddr = (m_addr - m_pre + DEPTH) % DEPTH;
        m_left  = m_post;
        m_phase = (m_post == 0) ? 5 : 4;
      end
      4: if (valid) begin
        m_left--;
        if (m_left == 0) m_phase = 5;
      end
      default: m_phase = 0;
    endcase
    if (wrote) m_addr = (m_addr + 1) % DEPTH;
  endtask

  // One clock cycle: apply inputs, check at the falling edge, advance the model at the rising edge.
  task automatic drive(input bit st, input bit ab, input bit vl, input bit tr);
    start = st; abort = ab; valid = vl; trig_run = tr;
    @(negedge clock);
    if (m_live && !reset) begin
      compare_all();
      if (trig_arm === 1'b1) arm_cnt++;
      if (wr_en === 1'b1 && wr_addr == AW'(DEPTH - 1)) saw_wrap = 1;
    end
    @(posedge clock);
    model_update();
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 0; abort = 0; valid = 0; trig_run = 0;
    cfg_rising = '0; cfg_falling = '0; cfg_pre = '0; cfg_post = '0;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    reset = 1'b0;
    drive(0, 0, 1, 0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);

    // Nominal capture: pre=3, post=2, trigger five cycles after the arm pulse.
    cfg_rising = 8'hA5; cfg_falling = 8'h3C; cfg_pre = 4'd3; cfg_post = 4'd2;
    arm_cnt = 0;
    drive(1, 0, 1, 0);
    chk("s1_start_addr0", 32'(wr_addr), 32'd0);
    repeat (3) drive(0, 0, 1, 0);
    chk("s1_arm", 32'(trig_arm), 32'd1);
    chk("s1_arm_addr", 32'(wr_addr), 32'd3);
    drive(0, 0, 1, 0);
    repeat (4) drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);
    chk("s1_trig_addr", 32'(trig_addr), 32'd8);
    chk("s1_start_addr", 32'(start_addr), 32'd5);
    repeat (2) drive(0, 0, 1, 0);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_final_addr", 32'(wr_addr), 32'd11);
    drive(0, 0, 1, 0);
    chk("s1_arm_pulses", 32'(arm_cnt), 32'd1);

    // Zero pre and post: arm right after start, done right after trigger.
    cfg_rising = 8'h0F; cfg_pre = 4'd0; cfg_post = 4'd0;
    drive(1, 0, 0, 0);
    chk("s2_arm_next", 32'(trig_arm), 32'd1);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);
    chk("s2_done", 32'(done), 32'd1);
    chk("s2_trig_addr", 32'(trig_addr), 32'd1);
    chk("s2_final_addr", 32'(wr_addr), 32'd2);

    // Toggled valid during pre-fill, then wrap the address, then abort in WAIT.
    cfg_pre = 4'd4; cfg_post = 4'd5;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, i % 2 == 1, 0);
    chk("s3_arm_after8", 32'(trig_arm), 32'd1);
    chk("s3_pre_addr", 32'(wr_addr), 32'd4);
    drive(0, 0, 1, 0);
    repeat (15) drive(0, 0, 1, 0);
    chk("s3_wrap_addr", 32'(wr_addr), 32'd4);
    chk("s3_saw_wrap", 32'(saw_wrap), 32'd1);
    drive(0, 1, 1, 0);
    chk("s3_abort_busy", 32'(busy), 32'd0);
    chk("s3_abort_addr", 32'(wr_addr), 32'd4);
    repeat (3) drive(0, 0, 1, 1);

    // start and abort together in IDLE: abort wins, selects unchanged.
    cfg_rising = 8'h55;
    drive(1, 1, 1, 0);
    chk("s4_busy", 32'(busy), 32'd0);
    chk("s4_rising_kept", 32'(trig_rising), 32'h0F);

    // start during POST is ignored.
    cfg_rising = 8'hC3; cfg_pre = 4'd1; cfg_post = 4'd3;
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);
    cfg_rising = 8'h99;
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("s5_done", 32'(done), 32'd1);
    chk("s5_rising_kept", 32'(trig_rising), 32'hC3);
    chk("s5_final_addr", 32'(wr_addr), 32'd6);

    // Reset in the middle of WAIT.
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    reset = 1'b1;
    drive(0, 0, 1, 0);
    reset = 1'b0;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trig_addr", 32'(trig_addr), 32'd0);
    chk("rst_rising", 32'(trig_rising), 32'd0);

    // Randomized traffic, including pre+post overlap beyond the buffer depth.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_rising  = 8'($urandom);
        cfg_falling = 8'($urandom);
        cfg_pre     = 4'($urandom);
        cfg_post    = 4'($urandom);
      end
      reset = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Sequences one logic-analyzer acquisition around the per-channel edge trigger and the sample RAM.
- Latches trigger edge selects and pulses trigger arm after the pre-trigger fill.
- Generates circular sample-RAM write addresses, counts post-trigger samples and reports trigger/start addresses to the host controller.
- Sits between the host command/config registers, the trigger, and the sample buffer.

Parameters:
- SAMPLE_WIDTH, 8, channel count; width of edge-select vectors.
- ADDR_WIDTH, 12, sample RAM address width; depth = 2**ADDR_WIDTH.

Ports:
- clock  in  1  system clock; every register uses posedge clock.
- reset  in  1  synchronous, active-high; one clock, sync reset, polarity fixed.
- start  in  1  single-cycle command: begin acquisition.
- abort  in  1  single-cycle command: cancel acquisition.
- valid  in  1  sample strobe; one sample per valid cycle.
- cfg_rising  in  SAMPLE_WIDTH  rising-edge channel select.
- cfg_falling  in  SAMPLE_WIDTH  falling-edge channel select.
- cfg_pre  in  ADDR_WIDTH  samples to store before arming.
- cfg_post  in  ADDR_WIDTH  samples to store after trigger.
- trig_run  in  1  trigger-fired indication from the trigger.
- trig_arm  out  1  single-cycle arm pulse to the trigger.
- trig_rising  out  SAMPLE_WIDTH  latched rising selects.
- trig_falling  out  SAMPLE_WIDTH  latched falling selects.
- wr_en  out  1  sample RAM write enable.
- wr_addr  out  ADDR_WIDTH  sample RAM write address.
- trig_addr  out  ADDR_WIDTH  address written in the trigger cycle.
- start_addr  out  ADDR_WIDTH  address of oldest valid pre-trigger sample.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  level; high in DONE.

Behaviour:
- Reset: state IDLE; all outputs 0.
- States: IDLE, PRE, ARM, WAIT, POST, DONE.
- IDLE/DONE + start:
  - latch cfg_rising/falling into trig_rising/falling; latch cfg_pre and cfg_post;
  - wr_addr <= 0; counter <= 0; done <= 0;
  - next state PRE, or ARM if cfg_pre == 0.
- start while busy: ignored.
- abort (any state, including with start in the same cycle): next state IDLE; done stays 0; wr_en forced 0 that cycle; latched selects unchanged.
- wr_en = valid & (state in PRE, ARM, WAIT, POST); combinational from registered state.
- Each write: wr_addr increments the next cycle, wrapping 2**ADDR_WIDTH-1 -> 0.
- PRE: count valid; when count reaches cfg_pre (counting that cycle's write) -> ARM.
- ARM: exactly one cycle; trig_arm = 1 (registered); trig_run ignored -> WAIT.
- WAIT:
  - trig_run high -> trig_addr <= wr_addr (write of that cycle, valid or not); start_addr <= wr_addr - cfg_pre (mod depth); counter <= 0;
  - next state POST, or DONE if cfg_post == 0.
- POST: count valid; on the cfg_post-th write -> DONE.
- DONE: done = 1, busy = 0, wr_en = 0; holds until start or reset.
- Overlap: if cfg_pre + cfg_post exceeds depth, oldest samples are overwritten; no error is flagged. Host handles the overlap.
- Counter width: ADDR_WIDTH+1 bits. No arithmetic overflow.

Optional Feature:
- Macro: CAPTURE_TIMEOUT_EN.
- Defined:
  - adds input cfg_timeout (32 bits) and output timed_out (1 bit, reset 0, cleared on start);
  - in WAIT, counts valid cycles; count == cfg_timeout with cfg_timeout != 0 forces the trigger path as if trig_run = 1 and sets timed_out = 1;
  - trig_run in the same cycle takes priority, so timed_out stays 0.
- Undefined: ports absent; WAIT lasts indefinitely.

Decomposition:
- Package capture_pkg:
  - state enum capture_state_t (3-bit, IDLE = 0);
  - localparam TIMEOUT_WIDTH = 32.
- Sub-module: capture_addr_gen — wrap-around write-address counter with increment enable and clear. FSM and counters stay in capture_sequencer.

Test Plan:
- ADDR_WIDTH = 4, cfg_pre = 3, cfg_post = 2, valid constant 1, trig_run pulsed 5 cycles after trig_arm -> wr_addr 0..2 in PRE; one trig_arm pulse; trig_addr = 8; start_addr = 5; done after two POST writes; final wr_addr = 11.
- cfg_pre = 0, cfg_post = 0, start -> trig_arm the next cycle; trig_run -> DONE the next cycle; no POST writes.
- valid toggled 1/0 with cfg_pre = 4 -> PRE lasts 8 cycles; wr_en only on valid cycles; wrap test (ADDR_WIDTH = 4, 20 writes) shows wr_addr 15 -> 0.
- abort in WAIT, and abort with start in IDLE -> state IDLE; done = 0; busy = 0; no further wr_en.
- start during POST -> ignored; capture completes normally; reset mid-WAIT -> all outputs 0 the next cycle.
- CAPTURE_TIMEOUT_EN, cfg_timeout = 10, no trig_run -> after 10 valid cycles in WAIT: timed_out = 1, POST entered; cfg_timeout = 0 -> never times out.
